pilha_exec: RTL and testbench
=============================

# pilha_exec

Operand stack and execution engine for the 8-bit ALU: it is the datapath end of the 4-state input FSM. It consumes the FSM control strobes (A push, B push, op latch, execute, reuse select, FSM reset) and returns `pode_avancar`, the stall condition that gates the FSM's 10→11 transition. It holds both operands and the opcode, runs single-cycle logic/arithmetic ops and an optional multi-cycle shift-add multiply, and keeps the result register that feeds the reuse path.

## Interface
- No parameters; data width fixed at 8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high; clears all state.
- `habilitaA` in 1: push operand A, single-cycle strobe.
- `habilitaB` in 1: push operand B, single-cycle strobe.
- `habilitaOp` in 1: latch `op_in`, single-cycle strobe.
- `habilitaExec` in 1: level, held high for the whole of FSM state 11.
- `selMuxA` in 1: with `habilitaA`, push `res` instead of `dado_in` (reuse).
- `resetFSM` in 1: clears stack, opcode and error; `res`/flags kept.
- `dado_in` in 8: operand from switches.
- `op_in` in 3: opcode.
- `res` out 8: result register.
- `carry`, `zero`, `ovf` out 1 each: result flags.
- `pronto` out 1: result of current operation valid.
- `pode_avancar` out 1: to FSM `condicao_avanco`.
- `profundidade` out 2: stack depth, 0..2.
- `erro` out 1: sticky fault flag.

## Operation
- Stack: 2 entries. Entry0 = first push (A), entry1 = second push (B).
  - Push on `habilitaA` or `habilitaB` when depth < 2; depth increments.
  - Push source is `res` when `selMuxA`=1, else `dado_in`.
- Opcodes (A = entry0, B = entry1):
  - 000 ADD: carry = bit 8 out.
  - 001 SUB A−B: carry = borrow.
  - 010 AND, 011 OR, 100 XOR.
  - 101 NOT A.
  - 110 MUL: low 8 bits in `res`; `ovf` = high byte ≠ 0.
  - 111 PASS A.
- Flags:
  - `zero` = (res == 0).
  - `ovf` = signed overflow for ADD/SUB; MUL as above.
  - `carry` = 0 and `ovf` = 0 for logic ops.
- Opcode register has a valid bit, set by `habilitaOp` and cleared by `resetFSM`.
- `pode_avancar` = (depth == 2) & op_valid & (engine == IDLE).
- Engine FSM:
  - IDLE → DONE: `habilitaExec` & `pode_avancar` & op ≠ 110. `res`/flags load on this edge.
  - IDLE → MUL: same condition with op = 110. Loads multiplicand/multiplier; iteration counter = 0.
  - MUL → MUL for 8 iterations (one multiplier bit per cycle). On the 8th edge, `res`/flags load → DONE.
  - DONE → IDLE: on `resetFSM`, or when `habilitaExec` falls.
- `pronto` = 1 in DONE only.
- A new execute never retriggers from DONE while `habilitaExec` stays high.
- Boundary behaviour:
  - Push at depth 2: ignored; `erro` ← 1.
  - `habilitaA` and `habilitaB` in the same cycle: A pushed, B dropped, `erro` ← 1.
  - `habilitaExec` while `pode_avancar` = 0: no action.
  - `resetFSM` with any push or `habilitaOp` in the same cycle: reset wins.
  - `resetFSM` mid-MUL: abort to IDLE; `res`/flags unchanged.
  - `rst` mid-operation: immediate clear.
  - `habilitaOp` while an opcode is already valid: overwrite (no error).

## Timing
- Reset values: `res`=0, `carry`=0, `zero`=0, `ovf`=0, `pronto`=0, `pode_avancar`=0, `profundidade`=0, `erro`=0. Engine IDLE; op_valid=0.
- Push and op latch: visible the cycle after the strobe.
- `pode_avancar`: combinational from registers; valid the cycle after the second push or op latch, whichever is later.
- Single-cycle ops: exec accepted in cycle N → `res`, flags and `pronto` valid in cycle N+1.
- MUL: accepted in cycle N → 8 cycles in MUL → `res`/`pronto` valid in cycle N+9.
- `pode_avancar` drops the cycle after acceptance and stays 0 until `resetFSM`.

## Configuration
- `PILHA_MUL_SEQ_EN` defined:
  - Op 110 runs the sequential 8-iteration shift-add multiply as specified.
- `PILHA_MUL_SEQ_EN` undefined:
  - No MUL state or counter is built.
  - Op 110 takes the single-cycle path with `res`=0, flags=0, and `erro` ← 1.
  - `pronto` is valid at N+1.

## Test plan
- Push A=0x7F, push B=0x01, op=000, exec → `res`=0x80, `ovf`=1, `carry`=0, `zero`=0, `pronto` at N+1.
- Push 0x05, push 0x07, op=001 → `res`=0xFE, `carry`=1; then `resetFSM` plus reuse push (`selMuxA`) → entry0=0xFE, `profundidade`=1.
- Push 0x10, push 0x20, op=110, exec (macro on) → `pronto` at exactly N+9, `res`=0x00, `ovf`=1, `zero`=1. With the macro off: `res`=0, `erro`=1 at N+1.
- Three pushes without reset → depth stays 2, `erro`=1; A and B in the same cycle from depth 0 → depth 1, `erro`=1.
- Depth 2 with op not yet latched → `pode_avancar`=0 and exec ignored; after `habilitaOp` → `pode_avancar`=1 the next cycle.
- MUL started, `resetFSM` at iteration 4 → IDLE, `res` holds previous value, `pronto`=0, `profundidade`=0. Async `rst` pulse mid-MUL → all outputs zero with no clock edge.

Source files
------------

// File: rtl/pilha_exec.sv
// pilha_exec: two-entry operand stack, opcode latch and ALU engine for the 8-bit ALU.
// Define PILHA_MUL_SEQ_EN to build the sequential shift-add multiply for opcode 110.
module pilha_exec (
  input  logic       clk,
  input  logic       rst,
  input  logic       habilitaA,
  input  logic       habilitaB,
  input  logic       habilitaOp,
  input  logic       habilitaExec,
  input  logic       selMuxA,
  input  logic       resetFSM,
  input  logic [7:0] dado_in,
  input  logic [2:0] op_in,
  output logic [7:0] res,
  output logic       carry,
  output logic       zero,
  output logic       ovf,
  output logic       pronto,
  output logic       pode_avancar,
  output logic [1:0] profundidade,
  output logic       erro
);
`ifdef PILHA_MUL_SEQ_EN
  typedef enum logic [1:0] {S_IDLE, S_DONE, S_MUL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif
  state_t r_state, w_state_nx;
  logic [7:0] r_stk0, r_stk1, r_res;
  logic [1:0] r_depth;
  logic [2:0] r_op;
  logic       r_op_valid, r_erro, r_carry, r_zero, r_ovf;
  logic [7:0] w_push, w_res;
  logic [8:0] w_sum, w_dif;
  logic       w_c, w_v, w_z, w_go, w_is_mul, w_single;
`ifdef PILHA_MUL_SEQ_EN
  logic [15:0] r_mcand, r_acc, w_acc_nx;
  logic [7:0]  r_mplier;
  logic [2:0]  r_cnt;
  assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : 16'd0);
  assign w_single = w_go & ~w_is_mul;
`else
  assign w_single = w_go;
`endif
  assign pode_avancar = (r_depth == 2'd2) & r_op_valid & (r_state == S_IDLE);
  assign w_go         = habilitaExec & pode_avancar & ~resetFSM;
  assign w_is_mul     = (r_op == 3'd6);
  assign w_push       = selMuxA ? r_res : dado_in;
  assign w_sum        = {1'b0, r_stk0} + {1'b0, r_stk1};
  assign w_dif        = {1'b0, r_stk0} - {1'b0, r_stk1};
  assign res          = r_res;
  assign carry        = r_carry;
  assign zero         = r_zero;
  assign ovf          = r_ovf;
  assign erro         = r_erro;
  assign profundidade = r_depth;
  assign pronto       = (r_state == S_DONE);
  always_comb begin
    w_res = 8'd0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      3'd0: begin
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_v   = (r_stk0[7] == r_stk1[7]) & (w_sum[7] != r_stk0[7]);
      end
      3'd1: begin
        w_res = w_dif[7:0];
        w_c   = w_dif[8];
        w_v   = (r_stk0[7] != r_stk1[7]) & (w_dif[7] != r_stk0[7]);
      end
      3'd2:    w_res = r_stk0 & r_stk1;
      3'd3:    w_res = r_stk0 | r_stk1;
      3'd4:    w_res = r_stk0 ^ r_stk1;
      3'd5:    w_res = ~r_stk0;
      3'd7:    w_res = r_stk0;
      default: w_res = 8'd0;
    endcase
    // an unsupported multiply reports all flags clear, including zero
    w_z = (w_res == 8'd0) & ~w_is_mul;
  end
  always_comb begin
    w_state_nx = r_state;
    if (resetFSM)
      w_state_nx = S_IDLE;
    else if (r_state == S_IDLE && w_go)
`ifdef PILHA_MUL_SEQ_EN
      w_state_nx = w_is_mul ? S_MUL : S_DONE;
    else if (r_state == S_MUL && r_cnt == 3'd7)
      w_state_nx = S_DONE;
`else
      w_state_nx = S_DONE;
`endif
    else if (r_state == S_DONE && !habilitaExec)
      w_state_nx = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stk0     <= 8'd0;
      r_stk1     <= 8'd0;
      r_depth    <= 2'd0;
      r_op       <= 3'd0;
      r_op_valid <= 1'b0;
      r_erro     <= 1'b0;
      r_res      <= 8'd0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (resetFSM) begin
        r_depth    <= 2'd0;
        r_op_valid <= 1'b0;
        r_erro     <= 1'b0;
      end else begin
        if (habilitaA | habilitaB) begin
          if (r_depth == 2'd2 || (habilitaA & habilitaB)) r_erro <= 1'b1;
          if (r_depth != 2'd2) begin
            if (r_depth == 2'd0) r_stk0 <= w_push;
            else                 r_stk1 <= w_push;
            r_depth <= r_depth + 2'd1;
          end
        end
        // consuming the opcode keeps pode_avancar low until the next resetFSM
        if (w_go) r_op_valid <= 1'b0;
        if (habilitaOp) begin
          r_op       <= op_in;
          r_op_valid <= 1'b1;
        end
`ifndef PILHA_MUL_SEQ_EN
        if (w_go && w_is_mul) r_erro <= 1'b1;
`endif
      end
      if (w_single) begin
        r_res   <= w_res;
        r_carry <= w_c;
        r_zero  <= w_z;
        r_ovf   <= w_v;
      end
`ifdef PILHA_MUL_SEQ_EN
      else if (r_state == S_MUL && !resetFSM && r_cnt == 3'd7) begin
        r_res   <= w_acc_nx[7:0];
        r_carry <= 1'b0;
        r_zero  <= (w_acc_nx[7:0] == 8'd0);
        r_ovf   <= |w_acc_nx[15:8];
      end
`endif
    end
  end
`ifdef PILHA_MUL_SEQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= 16'd0;
      r_mplier <= 8'd0;
      r_acc    <= 16'd0;
      r_cnt    <= 3'd0;
    end else if (w_go && w_is_mul) begin
      r_mcand  <= {8'd0, r_stk0};
      r_mplier <= r_stk1;
      r_acc    <= 16'd0;
      r_cnt    <= 3'd0;
    end else if (r_state == S_MUL && !resetFSM) begin
      r_acc    <= w_acc_nx;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 3'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pilha_exec.sv
// tb_pilha_exec: directed scoreboard bench for the operand stack / execution engine.
module tb_pilha_exec;
  logic       clk = 1'b0, rst = 1'b1;
  logic       habilitaA = 0, habilitaB = 0, habilitaOp = 0, habilitaExec = 0, selMuxA = 0, resetFSM = 0;
  logic [7:0] dado_in = 8'd0;
  logic [2:0] op_in = 3'd0;
  logic [7:0] res;
  logic       carry, zero, ovf, pronto, pode_avancar, erro;
  logic [1:0] profundidade;
  typedef struct packed {logic [7:0] r; logic c; logic z; logic v;} exp_t;
  exp_t sb[$];
  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [7:0] last_res;
`ifdef PILHA_MUL_SEQ_EN
  localparam int MUL_LAT = 9;
`else
  localparam int MUL_LAT = 1;
`endif
  pilha_exec dut (
    .clk(clk), .rst(rst), .habilitaA(habilitaA), .habilitaB(habilitaB), .habilitaOp(habilitaOp),
    .habilitaExec(habilitaExec), .selMuxA(selMuxA), .resetFSM(resetFSM), .dado_in(dado_in),
    .op_in(op_in), .res(res), .carry(carry), .zero(zero), .ovf(ovf), .pronto(pronto),
    .pode_avancar(pode_avancar), .profundidade(profundidade), .erro(erro)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sbb, ua, ub, t;
    e = '0; sa = $signed(a); sbb = $signed(b); ua = a; ub = b;
    case (op)
      3'd0: begin t = ua + ub; e.r = t[7:0]; e.c = (t > 255); e.v = (sa + sbb > 127) || (sa + sbb < -128); end
      3'd1: begin t = ua - ub; e.r = t[7:0]; e.c = (ua < ub); e.v = (sa - sbb > 127) || (sa - sbb < -128); end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = ~a;
      3'd6: begin t = ua * ub; e.r = t[7:0]; e.v = (t > 255); end
      default: e.r = a;
    endcase
    e.z = (e.r == 8'd0);
`ifndef PILHA_MUL_SEQ_EN
    if (op == 3'd6) e = '0;
`endif
    return e;
  endfunction
  task automatic step(); @(posedge clk); #1; endtask
  task automatic push(input logic is_a, input logic sel, input logic [7:0] d);
    habilitaA = is_a; habilitaB = !is_a; selMuxA = sel; dado_in = d;
    step();
    habilitaA = 0; habilitaB = 0; selMuxA = 0;
  endtask
  task automatic setop(input logic [2:0] op);
    habilitaOp = 1; op_in = op; step(); habilitaOp = 0;
  endtask
  task automatic rfsm(); resetFSM = 1; step(); resetFSM = 0; endtask
  task automatic exec(input int lat, input string tag);
    int cnt;
    exp_t e;
    cnt = 0;
    habilitaExec = 1;
    do begin step(); cnt++; end while (!pronto && cnt < 20);
    chk({tag, "_lat"}, cnt, lat);
    chk({tag, "_pode_done"}, pode_avancar, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_res"}, {res, carry, zero, ovf}, {e.r, e.c, e.z, e.v});
    end
    last_res = res;
    step();
    chk({tag, "_hold"}, pronto, 1);
    habilitaExec = 0;
    step();
    chk({tag, "_drop"}, {pronto, pode_avancar}, 2'b00);
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat, input string tag);
    push(1, 0, a); push(0, 0, b); setop(op);
    sb.push_back(model(op, a, b));
    exec(lat, tag);
  endtask
  initial begin
    #1;
    chk("reset", {res, carry, zero, ovf, pronto, pode_avancar, profundidade, erro}, 0);
    step(); rst = 0; step();
    push(1, 0, 8'h7F); push(0, 0, 8'h01);
    chk("depth2", profundidade, 2);
    chk("pode_no_op", pode_avancar, 0);
    habilitaExec = 1; step(); habilitaExec = 0;
    chk("exec_ignored", {pronto, res}, 0);
    setop(3'd0);
    chk("pode_after_op", pode_avancar, 1);
    sb.push_back(exp_t'{r: 8'h80, c: 1'b0, z: 1'b0, v: 1'b1});
    exec(1, "add7f");
    chk("add_noerr", erro, 0);
    rfsm();
    run_op(8'h05, 8'h07, 3'd1, 1, "sub");
    chk("sub_fe", {res, carry}, {8'hFE, 1'b1});
    rfsm();
    push(1, 1, 8'h00);
    chk("reuse_depth", profundidade, 1);
    push(0, 0, 8'h01); setop(3'd0);
    sb.push_back(model(3'd0, 8'hFE, 8'h01));
    exec(1, "reuse_add");
    rfsm();
    run_op(8'hF0, 8'h3C, 3'd2, 1, "and"); rfsm();
    run_op(8'hF0, 8'h3C, 3'd3, 1, "or");  rfsm();
    run_op(8'hF0, 8'h3C, 3'd4, 1, "xor"); rfsm();
    run_op(8'hF0, 8'h3C, 3'd5, 1, "not"); rfsm();
    run_op(8'h5A, 8'h3C, 3'd7, 1, "pass"); rfsm();
    run_op(8'hFF, 8'h01, 3'd0, 1, "add_wrap"); rfsm();
    run_op(8'h00, 8'h01, 3'd1, 1, "sub_borrow"); rfsm();
    run_op(8'h80, 8'h01, 3'd1, 1, "sub_ovf"); rfsm();
    run_op(8'h10, 8'h20, 3'd6, MUL_LAT, "mul");
`ifdef PILHA_MUL_SEQ_EN
    chk("mul_erro", erro, 0);
    rfsm();
    run_op(8'h0D, 8'h0B, 3'd6, MUL_LAT, "mul2");
`else
    chk("mul_erro", erro, 1);
`endif
    rfsm();
    chk("rfsm_clear", {erro, profundidade, pode_avancar}, 0);
    push(1, 0, 8'h01); push(0, 0, 8'h02); push(1, 0, 8'h03);
    chk("overflow_push", {profundidade, erro}, {2'd2, 1'b1});
    rfsm();
    habilitaA = 1; habilitaB = 1; dado_in = 8'h11; step(); habilitaA = 0; habilitaB = 0;
    chk("ab_same", {profundidade, erro}, {2'd1, 1'b1});
    rfsm();
    resetFSM = 1; habilitaA = 1; habilitaOp = 1; step();
    resetFSM = 0; habilitaA = 0; habilitaOp = 0;
    chk("reset_wins", {profundidade, pode_avancar}, 0);
    push(1, 0, 8'h0C); push(0, 0, 8'h03); setop(3'd0); setop(3'd3);
    chk("op_overwrite", erro, 0);
    sb.push_back(model(3'd3, 8'h0C, 8'h03));
    exec(1, "overwrite");
    rfsm();
`ifdef PILHA_MUL_SEQ_EN
    push(1, 0, 8'h10); push(0, 0, 8'h21); setop(3'd6);
    habilitaExec = 1;
    repeat (5) step();
    resetFSM = 1; step(); resetFSM = 0; habilitaExec = 0;
    chk("mul_abort", {pronto, profundidade, res}, {1'b0, 2'd0, last_res});
    repeat (8) step();
    chk("mul_abort_stay", {pronto, res}, {1'b0, last_res});
`endif
    push(1, 0, 8'h03); push(0, 0, 8'h04); setop(3'd0);
    habilitaExec = 1; step();
    chk("pre_rst_res", res, 8'h07);
    #2 rst = 1;
    #1 chk("async_rst", {res, carry, zero, ovf, pronto, pode_avancar, profundidade, erro}, 0);
    habilitaExec = 0;
    step(); rst = 0; step();
    chk("post_rst", {profundidade, pronto}, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
